// File: rtl/safe_lock_pkg.sv
// Shared types and constants for the safe-lock datapath (p2s/s2p word width, s2p output state).
package safe_lock_pkg;

  typedef enum logic {EMPTY, FULL} s2p_state_t;

  localparam int unsigned LOCK_WORD_W = 8;

endpackage

// File: rtl/s2p.sv
// Serial-to-parallel deserializer: collects N bits LSB first and hands each word to a
// ready/valid parallel port through a one-word holding register.
module s2p
  import safe_lock_pkg::*;
#(
  parameter int unsigned N = LOCK_WORD_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         ser_valid,
  input  logic         ser_data,
  output logic         ser_ready,
  output logic         par_valid,
  output logic [N-1:0] par_data,
  input  logic         par_ready
);

  localparam int unsigned N_BITS = (N > 1) ? $clog2(N) : 1;
  localparam logic [N_BITS-1:0] CntLast = N_BITS'(N - 1);

  logic [N-1:0]      sreg_q, sreg_d;
  logic [N-1:0]      par_q, par_d;
  logic [N_BITS-1:0] cnt_q, cnt_d;
  s2p_state_t        state_q, state_d;

  logic last_bit;
  logic ser_fire;
  logic par_fire;
  logic complete;

  assign last_bit  = (cnt_q == CntLast);
  assign par_valid = (state_q == FULL);
  assign par_data  = par_q;
  // Only the final bit of a word can stall, and only if the held word is not leaving now.
  assign ser_ready = !(last_bit && (state_q == FULL) && !par_ready);
  assign ser_fire  = ser_valid && ser_ready;
  assign par_fire  = par_valid && par_ready;
  assign complete  = ser_fire && last_bit;

  always_comb begin
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    state_d = state_q;
    if (ser_fire) begin
      sreg_d = {ser_data, sreg_q[N-1:1]};
      cnt_d  = last_bit ? '0 : cnt_q + N_BITS'(1);
      if (last_bit) begin
        par_d = sreg_d;
      end
    end
    case (state_q)
      EMPTY: begin
        if (complete) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (par_fire && !complete) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sreg_q  <= '0;
      par_q   <= '0;
      cnt_q   <= '0;
      state_q <= EMPTY;
    end else begin
      sreg_q  <= sreg_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_s2p.sv
// Directed bench for s2p at N=8 plus a randomised N=5 loopback driven by a serializer model.
module tb_s2p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       sv8, sd8, sr8, pv8, pr8;
  logic [7:0] pd8;
  logic       sv5, sd5, sr5, pv5, pr5;
  logic [4:0] pd5;

  int checks = 0;
  int errors = 0;

  s2p #(.N(8)) u_s2p8 (
    .clk      (clk),
    .rstn     (rstn),
    .ser_valid(sv8),
    .ser_data (sd8),
    .ser_ready(sr8),
    .par_valid(pv8),
    .par_data (pd8),
    .par_ready(pr8)
  );

  s2p #(.N(5)) u_s2p5 (
    .clk      (clk),
    .rstn     (rstn),
    .ser_valid(sv5),
    .ser_data (sd5),
    .ser_ready(sr5),
    .par_valid(pv5),
    .par_data (pd5),
    .par_ready(pr5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit8(input logic b);
    sd8 = b;
    sv8 = 1'b1;
    tick();
  endtask

  task automatic send_word8(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit8(w[i]);
    sv8 = 1'b0;
  endtask

  // Protocol monitors: held word stable, stalled last bit not consumed, N=5 counter bounded.
  logic       hold8 = 1'b0, hold5 = 1'b0, stall8 = 1'b0;
  logic [7:0] hd8;
  logic [4:0] hd5;
  logic [2:0] sc8;

  always @(negedge clk) begin
    hold8  = rstn && pv8 && !pr8;
    hold5  = rstn && pv5 && !pr5;
    stall8 = rstn && sv8 && !sr8;
    hd8    = pd8;
    hd5    = pd5;
    sc8    = u_s2p8.cnt_q;
  end

  always begin
    @(posedge clk);
    #1;
    if (hold8) check("hold8", 32'(pd8), 32'(hd8));
    if (hold5) check("hold5", 32'(pd5), 32'(hd5));
    if (stall8) check("stall8_cnt", 32'(u_s2p8.cnt_q), 32'(sc8));
    if (rstn) check("cnt5_range", 32'(u_s2p5.cnt_q <= 3'd4), 32'd1);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [7:0] wv;
  logic [4:0] in_w [200];
  logic [4:0] cur, pdata;
  logic       s_fire, p_fire;
  int         stalls, bits, exp_cnt, cyc, rx, tx_w, tx_b;

  initial begin
    rstn = 1'b0;
    sv8 = 1'b0; sd8 = 1'b0; pr8 = 1'b0;
    sv5 = 1'b0; sd5 = 1'b0; pr5 = 1'b0;
    tick();
    tick();
    check("rst_pv8", 32'(pv8), 32'd0);
    check("rst_pd8", 32'(pd8), 32'd0);
    check("rst_sr8", 32'(sr8), 32'd1);
    check("rst_cnt8", 32'(u_s2p8.cnt_q), 32'd0);
    check("rst_pv5", 32'(pv5), 32'd0);
    rstn = 1'b1;

    // 1: single word, downstream always ready
    pr8 = 1'b1;
    send_word8(8'hA5);
    check("t1_pv", 32'(pv8), 32'd1);
    check("t1_pd", 32'(pd8), 32'hA5);
    tick();
    check("t1_pv_drop", 32'(pv8), 32'd0);

    // 2: back-to-back with downstream stalled, then released
    pr8 = 1'b0;
    send_word8(8'h3C);
    check("t2_pv", 32'(pv8), 32'd1);
    check("t2_pd", 32'(pd8), 32'h3C);
    wv = 8'hC3;
    for (int i = 0; i < 7; i++) begin
      send_bit8(wv[i]);
      check("t2_held", 32'(pd8), 32'h3C);
    end
    sd8 = wv[7];
    sv8 = 1'b1;
    #1;
    check("t2_sr_low", 32'(sr8), 32'd0);
    tick();
    check("t2_pv_stall", 32'(pv8), 32'd1);
    check("t2_pd_stall", 32'(pd8), 32'h3C);
    check("t2_cnt_stall", 32'(u_s2p8.cnt_q), 32'd7);
    pr8 = 1'b1;
    #1;
    check("t2_sr_high", 32'(sr8), 32'd1);
    tick();
    sv8 = 1'b0;
    check("t2_pv_next", 32'(pv8), 32'd1);
    check("t2_pd_next", 32'(pd8), 32'hC3);
    tick();
    check("t2_pv_drain", 32'(pv8), 32'd0);

    // 3: sixteen words streamed with no gaps
    pr8 = 1'b1;
    stalls = 0;
    for (int w = 1; w <= 16; w++) begin
      wv = 8'(w);
      for (int i = 0; i < 8; i++) begin
        sd8 = wv[i];
        sv8 = 1'b1;
        #1;
        if (!sr8) stalls++;
        tick();
        if (i == 7) begin
          check("t3_pv", 32'(pv8), 32'd1);
          check("t3_pd", 32'(pd8), 32'(wv));
        end
      end
    end
    sv8 = 1'b0;
    check("t3_stalls", 32'(stalls), 32'd0);
    tick();
    check("t3_pv_drain", 32'(pv8), 32'd0);

    // 4: reset with a pending word and a partial word
    pr8 = 1'b0;
    send_word8(8'h55);
    check("t4_pv_pend", 32'(pv8), 32'd1);
    for (int i = 0; i < 4; i++) send_bit8(1'b1);
    sv8 = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("t4_pv", 32'(pv8), 32'd0);
    check("t4_pd", 32'(pd8), 32'd0);
    check("t4_sr", 32'(sr8), 32'd1);
    check("t4_cnt", 32'(u_s2p8.cnt_q), 32'd0);
    pr8 = 1'b1;
    send_word8(8'h0F);
    check("t4_pv_after", 32'(pv8), 32'd1);
    check("t4_pd_after", 32'(pd8), 32'h0F);
    tick();

    // 5: gappy ser_valid, counter must freeze on idle cycles
    wv = 8'h96;
    bits = 0;
    cyc = 0;
    while (bits < 8 && cyc < 400) begin
      sv8 = 1'($urandom_range(0, 1));
      sd8 = wv[bits];
      tick();
      cyc++;
      if (sv8) bits++;
      exp_cnt = bits % 8;
      check("t5_cnt", 32'(u_s2p8.cnt_q), 32'(exp_cnt));
    end
    sv8 = 1'b0;
    check("t5_bits", 32'(bits), 32'd8);
    check("t5_pv", 32'(pv8), 32'd1);
    check("t5_pd", 32'(pd8), 32'h96);
    tick();

    // 6: N=5 loopback from a serializer model with random backpressure
    for (int i = 0; i < 200; i++) in_w[i] = 5'($urandom_range(0, 31));
    tx_w = 0; tx_b = 0; rx = 0; cyc = 0;
    while (rx < 200 && cyc < 20000) begin
      pr5 = 1'($urandom_range(0, 1));
      if (tx_w < 200) begin
        cur = in_w[tx_w];
        sv5 = ($urandom_range(0, 3) != 0);
        sd5 = cur[tx_b];
      end else begin
        sv5 = 1'b0;
      end
      @(negedge clk);
      s_fire = sv5 && sr5;
      p_fire = pv5 && pr5;
      pdata  = pd5;
      tick();
      cyc++;
      if (p_fire) begin
        if (rx < 200) check("t6_word", 32'(pdata), 32'(in_w[rx]));
        rx++;
      end
      if (s_fire) begin
        if (tx_b == 4) begin
          tx_b = 0;
          tx_w++;
        end else begin
          tx_b++;
        end
      end
    end
    sv5 = 1'b0;
    pr5 = 1'b1;
    check("t6_count", 32'(rx), 32'd200);
    tick();
    tick();
    check("t6_no_extra", 32'(pv5), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
